// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI register-access engine: TXCMD prefixes, engine states,
// command FIFO entry layout and timeout counter sizing.
package ulpi_pkg;

  localparam logic [1:0] TxRegW = 2'b10;
  localparam logic [1:0] TxRegR = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StCmd,
    StWdata,
    StStp,
    StRturn,
    StRdata,
    StRwait,
    StAbort,
    StDone
  } eng_state_e;

  // Channel field sized for the largest supported N_CH (8)
  typedef struct packed {
    logic [2:0] ch;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  function automatic int unsigned to_cnt_w(int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/ulpi_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; the head entry is read from the flop array.
module ulpi_cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW + 1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ulpi_reg_access_ctrl.sv
// Multi-channel ULPI register-access engine: round-robin arbiter into a command FIFO, and an
// FSM that runs each command on the ULPI bus with DIR-abort retry and NXT timeout.
module ulpi_reg_access_ctrl
  import ulpi_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned TIMEOUT    = 15,
  localparam int unsigned ChW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_ULPI,
  input  logic              rst,
  input  logic [N_CH-1:0]   req_valid,
  output logic [N_CH-1:0]   req_ready,
  input  logic [N_CH-1:0]   req_we,
  input  logic [6*N_CH-1:0] req_addr,
  input  logic [8*N_CH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [ChW-1:0]    rsp_ch,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  input  logic              link_idle,
  output logic              busy,
  input  logic              DIR,
  input  logic              NXT,
  input  logic [7:0]        DATA_in,
  output logic [7:0]        DATA_out,
  output logic              STP
);

  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);
  localparam int unsigned ToW    = to_cnt_w(TIMEOUT);

  eng_state_e        state_q, state_d;
  cmd_t              cmd_q, cmd_d, push_cmd, fifo_head;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [ToW-1:0]    to_q, to_d, to_inc;
  logic              err_q, err_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [ChW-1:0]    rr_q, rr_d;
  logic              run_q, gnt_any, pop, fifo_full, fifo_empty, timed_out;

  ulpi_cmd_fifo #(
    .Width ($bits(cmd_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_ULPI),
    .rst_ni  (rst),
    .push_i  (gnt_any),
    .data_i  (push_cmd),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Two passes: channels at/after rr_q first, then the ones before it
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    rr_d      = rr_q;
    push_cmd  = '0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (run_q && !fifo_full && !gnt_any && req_valid[c] &&
            ((pass == 0) == (ChW'(c) >= rr_q))) begin
          gnt_any        = 1'b1;
          req_ready[c]   = 1'b1;
          rr_d           = ChW'((c + 1) % N_CH);
          push_cmd.ch    = 3'(c);
          push_cmd.we    = req_we[c];
          push_cmd.addr  = req_addr[6*c +: 6];
          push_cmd.wdata = req_wdata[8*c +: 8];
        end
      end
    end
  end

  assign busy = (state_q != StIdle) || !fifo_empty;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    retry_d   = retry_q;
    to_d      = to_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    pop       = 1'b0;
    DATA_out  = 8'h00;
    STP       = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = 8'h00;
    rsp_ch    = '0;
    timed_out = (to_q == ToW'(TIMEOUT - 1));
    to_inc    = (to_q == ToW'(TIMEOUT)) ? to_q : to_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && link_idle && !DIR) begin
          pop     = 1'b1;
          cmd_d   = fifo_head;
          err_d   = 1'b0;
          retry_d = '0;
          rdata_d = 8'h00;
          state_d = StCmd;
        end
      end
      StCmd: begin
        DATA_out = {cmd_q.we ? TxRegW : TxRegR, cmd_q.addr};
        // DIR with NXT is the PHY turning round for a read; anything else with DIR is a pre-emption
        if (DIR && !(NXT && !cmd_q.we)) state_d = StAbort;
        else if (NXT) state_d = cmd_q.we ? StWdata : StRturn;
        else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else to_d = to_inc;
      end
      StWdata: begin
        DATA_out = cmd_q.wdata;
        if (DIR && !NXT) state_d = StAbort;
        else if (NXT) state_d = StStp;
        else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else to_d = to_inc;
      end
      StStp: begin
        STP     = 1'b1;
        state_d = StDone;
      end
      StRturn: begin
        if (DIR) state_d = StRdata;
        else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else to_d = to_inc;
      end
      StRdata: begin
        rdata_d = DATA_in;
        state_d = StRwait;
      end
      StRwait: begin
        // A timeout here is only reported once the PHY has released the bus
        if (!DIR) begin
          err_d   = (to_q == ToW'(TIMEOUT));
          state_d = StDone;
        end else to_d = to_inc;
      end
      StAbort: begin
        if (!DIR && link_idle) begin
          if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = StCmd;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_ch    = ChW'(cmd_q.ch);
        rsp_data  = (err_q || cmd_q.we) ? 8'h00 : rdata_q;
        retry_d   = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) to_d = '0;
  end

  always_ff @(posedge clk_ULPI or negedge rst) begin
    if (!rst) begin
      run_q   <= 1'b0;
      rr_q    <= '0;
      state_q <= StIdle;
      cmd_q   <= '0;
      retry_q <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      run_q   <= 1'b1;
      rr_q    <= rr_d;
      state_q <= state_d;
      cmd_q   <= cmd_d;
      retry_q <= retry_d;
      to_q    <= to_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ulpi_reg_access_ctrl.sv
// Self-checking bench for ulpi_reg_access_ctrl: directed ULPI scenarios plus randomized
// two-channel traffic checked against a round-robin / PHY register-file model.
module tb_ulpi_reg_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we;
  logic [11:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_err, link_idle, busy, DIR, NXT, STP;
  logic [0:0]  rsp_ch;
  logic [7:0]  rsp_data, DATA_in, DATA_out;

  int errors = 0;
  int checks = 0;
  int rr = 0;
  logic [7:0] regs [64];
  logic       we_r [2];
  logic [5:0] a_r [2];
  logic [7:0] d_r [2];

  typedef struct {int ch; logic [5:0] addr; logic [7:0] d;} exp_t;
  exp_t q[$];

  ulpi_reg_access_ctrl #(
    .N_CH       (2),
    .FIFO_DEPTH (4),
    .MAX_RETRY  (3),
    .TIMEOUT    (15)
  ) dut (
    .clk_ULPI  (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ch    (rsp_ch),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .link_idle (link_idle),
    .busy      (busy),
    .DIR       (DIR),
    .NXT       (NXT),
    .DATA_in   (DATA_in),
    .DATA_out  (DATA_out),
    .STP       (STP)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Single-channel request; the model advances the round-robin preference past the winner
  task automatic post(input int ch, input logic we, input logic [5:0] addr, input logic [7:0] wd);
    req_valid = '0;
    req_valid[ch] = 1'b1;
    req_we[ch] = we;
    req_addr[6*ch +: 6] = addr;
    req_wdata[8*ch +: 8] = wd;
    #1 check("post_ready", 32'(req_ready), 32'(1 << ch));
    rr = (ch + 1) % 2;
    @(posedge clk);
    tick();
    req_valid = '0;
  endtask

  task automatic wait_txcmd();
    int n = 0;
    while (DATA_out == 8'h00 && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Acts as the PHY for one command with no pre-emption; rval is returned for reads
  task automatic serve(input logic we, input logic [5:0] addr, input logic [7:0] wd,
                       input logic [7:0] rval, input int ch);
    wait_txcmd();
    check("txcmd", 32'(DATA_out), 32'((we ? 8'h80 : 8'hC0) | {2'b00, addr}));
    NXT = 1'b1;
    tick();
    if (we) begin
      check("wdata", 32'(DATA_out), 32'(wd));
      tick();
      NXT = 1'b0;
      check("stp", 32'(STP), 32'd1);
      check("stp_data", 32'(DATA_out), 32'd0);
    end else begin
      NXT = 1'b0;
      DIR = 1'b1;
      check("rturn_data", 32'(DATA_out), 32'd0);
      tick();
      DATA_in = rval;
      tick();
      DIR = 1'b0;
      DATA_in = 8'h00;
    end
    tick();
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_ch", 32'(rsp_ch), 32'(ch));
    check("rsp_err", 32'(rsp_err), 32'd0);
    check("rsp_data", 32'(rsp_data), we ? 32'd0 : 32'(rval));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int g;
    int saw;
    logic [1:0] mask;
    exp_t e;
    for (int i = 0; i < 64; i++) regs[i] = 8'(i * 7 + 3);
    rst = 1'b0;
    req_valid = 2'b11;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    link_idle = 1'b1;
    DIR = 1'b0;
    NXT = 1'b0;
    DATA_in = 8'h00;
    #12;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_data", 32'(DATA_out), 32'd0);
    check("rst_stp", 32'(STP), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_ch, rsp_data}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();

    // Write ch0: TXCMD 84, data 45, STP, response four cycles after pop
    post(0, 1'b1, 6'h04, 8'h45);
    check("t1_busy", 32'(busy), 32'd1);
    serve(1'b1, 6'h04, 8'h45, 8'h00, 0);
    tick();
    check("t1_idle", 32'(busy), 32'd0);

    // Read ch1 addr 0A returning 5A
    post(1, 1'b0, 6'h0A, 8'h00);
    serve(1'b0, 6'h0A, 8'h00, 8'h5A, 1);
    tick();

    // Both channels requesting with the engine stalled: alternating grants until full
    link_idle = 1'b0;
    req_valid = 2'b11;
    req_we = 2'b11;
    for (int k = 0; k < 4; k++) begin
      req_addr = {6'(k + 32), 6'(k)};
      req_wdata = {8'(8'h20 + k), 8'(8'h10 + k)};
      #1 check("t3_grant", 32'(req_ready), 32'(1 << rr));
      e.ch = rr;
      e.addr = (rr == 0) ? 6'(k) : 6'(k + 32);
      e.d = (rr == 0) ? 8'(8'h10 + k) : 8'(8'h20 + k);
      q.push_back(e);
      rr = 1 - rr;
      @(posedge clk);
      tick();
    end
    #1 check("t3_full_ready", 32'(req_ready), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_stalled", 32'(DATA_out), 32'd0);
    req_valid = '0;
    link_idle = 1'b1;
    while (q.size() > 0) begin
      e = q.pop_front();
      serve(1'b1, e.addr, e.d, 8'h00, e.ch);
    end
    tick();

    // DIR pre-emption held 3 cycles, then the TXCMD is re-issued and completes
    post(0, 1'b1, 6'h11, 8'h3C);
    wait_txcmd();
    check("t4_txcmd", 32'(DATA_out), 32'h91);
    DIR = 1'b1;
    tick();
    check("t4_abort_data", 32'({STP, DATA_out}), 32'd0);
    tick();
    tick();
    DIR = 1'b0;
    serve(1'b1, 6'h11, 8'h3C, 8'h00, 0);
    tick();
    // Four aborts exhaust the retries
    post(0, 1'b1, 6'h12, 8'h77);
    for (int k = 0; k < 4; k++) begin
      wait_txcmd();
      check("t4_retx", 32'(DATA_out), 32'h92);
      DIR = 1'b1;
      tick();
      DIR = 1'b0;
      tick();
    end
    check("t4_err_valid", 32'(rsp_valid), 32'd1);
    check("t4_err", 32'(rsp_err), 32'd1);
    check("t4_err_data", 32'(rsp_data), 32'd0);
    tick();

    // NXT never comes: error after 15 cycles in the command state
    post(1, 1'b0, 6'h02, 8'h00);
    wait_txcmd();
    check("t5_txcmd", 32'(DATA_out), 32'hC2);
    for (int k = 0; k < 14; k++) tick();
    check("t5_early", 32'(rsp_valid), 32'd0);
    check("t5_hold", 32'(DATA_out), 32'hC2);
    tick();
    check("t5_valid", 32'(rsp_valid), 32'd1);
    check("t5_err", 32'(rsp_err), 32'd1);
    check("t5_ch", 32'(rsp_ch), 32'd1);
    check("t5_data", 32'(rsp_data), 32'd0);
    tick();
    check("t5_idle", 32'(busy), 32'd0);

    // Randomized traffic against the round-robin and PHY register models
    for (int r = 0; r < 12; r++) begin
      mask = 2'($urandom_range(1, 3));
      for (int c = 0; c < 2; c++) begin
        we_r[c] = 1'($urandom_range(0, 1));
        a_r[c] = 6'($urandom);
        d_r[c] = 8'($urandom);
        req_we[c] = we_r[c];
        req_addr[6*c +: 6] = a_r[c];
        req_wdata[8*c +: 8] = d_r[c];
      end
      req_valid = mask;
      g = mask[rr] ? rr : 1 - rr;
      #1 check("rnd_grant", 32'(req_ready), 32'(1 << g));
      rr = (g + 1) % 2;
      @(posedge clk);
      tick();
      req_valid = '0;
      serve(we_r[g], a_r[g], d_r[g], regs[a_r[g]], g);
      if (we_r[g]) regs[a_r[g]] = d_r[g];
      tick();
    end

    // Reset in the middle of a write with three commands still queued
    link_idle = 1'b0;
    for (int k = 0; k < 4; k++) post(0, 1'b1, 6'(k), 8'(k));
    link_idle = 1'b1;
    wait_txcmd();
    NXT = 1'b1;
    tick();
    check("t6_in_wdata", 32'(DATA_out), 32'd0);
    #1 rst = 1'b0;
    req_valid = 2'b11;
    #1;
    check("t6_rst_data", 32'({STP, DATA_out}), 32'd0);
    check("t6_rst_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    tick();
    NXT = 1'b0;
    req_valid = '0;
    rst = 1'b1;
    saw = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (rsp_valid || busy) saw++;
    end
    check("t6_quiet", 32'(saw), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
